// File: rtl/modulator_sequencer_if.sv
// Reference-triple stream into the modulator sequencer: one valid/ready
// handshake carrying three signed phase references.
interface modulator_sequencer_if #(
  parameter int W = 16
);
  logic                valid;
  logic                ready;
  logic signed [W-1:0] mod_a;
  logic signed [W-1:0] mod_b;
  logic signed [W-1:0] mod_c;

  modport master (output valid, mod_a, mod_b, mod_c, input ready);
  modport slave  (input valid, mod_a, mod_b, mod_c, output ready);
endinterface

// File: rtl/modulator_sequencer.sv
// Control-plane sequencer for the three-phase PWM modulator: clamps and
// double-buffers phase references, runs bridge start-up and latches faults.
module modulator_sequencer #(
  parameter int W                = 16,
  parameter int PRECHARGE_CYCLES = 8
) (
  input  logic                aclk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                fault_in,
  input  logic                fault_clear,
  input  logic                carrier_sync,
  input  logic [W-1:0]        period_in,
  modulator_sequencer_if.slave s,
  output logic [W-1:0]        pwm_period,
  output logic signed [W-1:0] mod_a,
  output logic signed [W-1:0] mod_b,
  output logic signed [W-1:0] mod_c,
  output logic                drv_enable,
  output logic [1:0]          state,
  output logic                fault_latched
);

  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_PRECHARGE = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] c;
  } triple_t;

  localparam logic [7:0] PC_LAST = 8'(PRECHARGE_CYCLES);

  state_t     state_q, state_nxt;
  triple_t    mods_q, mods_nxt;
  triple_t    shadow_q, shadow_nxt;
  logic       full_q, full_nxt;
  logic       drv_q, drv_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic [W-1:0] period_q, period_nxt;
  logic       ready_w;
  logic       take;
  triple_t    clamped;

  // Saturate a reference to [-p, +p]; one extra bit keeps the compare exact.
  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] v,
                                                input logic [W-1:0] p);
    logic signed [W:0] v_x;
    logic signed [W:0] p_x;
    v_x = {v[W-1], v};
    p_x = {1'b0, p};
    if (v_x > p_x)       clamp = p;
    else if (v_x < -p_x) clamp = -p;
    else                 clamp = v;
  endfunction

  assign ready_w   = (state_q != ST_RUN) || !full_q;
  assign take      = s.valid && ready_w;
  assign clamped.a = clamp(s.mod_a, period_q);
  assign clamped.b = clamp(s.mod_b, period_q);
  assign clamped.c = clamp(s.mod_c, period_q);

  // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt  = state_q;
    mods_nxt   = mods_q;
    shadow_nxt = shadow_q;
    full_nxt   = full_q;
    drv_nxt    = drv_q;
    cnt_nxt    = cnt_q;
    period_nxt = (state_q == ST_DISABLED) ? period_in : period_q;

    if (take) begin
      shadow_nxt = clamped;
      full_nxt   = 1'b1;
    end

    if (fault_in && state_q != ST_FAULT) begin
      state_nxt = ST_FAULT;
      drv_nxt   = 1'b0;
      mods_nxt  = '0;
      full_nxt  = 1'b0;
      cnt_nxt   = '0;
    end else begin
      unique case (state_q)
        ST_DISABLED: begin
          if (enable) begin
            // All low-side switches on to charge the bootstrap capacitors.
            state_nxt  = ST_PRECHARGE;
            drv_nxt    = 1'b1;
            mods_nxt.a = -period_in;
            mods_nxt.b = -period_in;
            mods_nxt.c = -period_in;
            cnt_nxt    = '0;
          end
        end
        ST_PRECHARGE, ST_RUN: begin
          if (!enable) begin
            state_nxt = ST_DISABLED;
            drv_nxt   = 1'b0;
            mods_nxt  = '0;
            full_nxt  = 1'b0;
            cnt_nxt   = '0;
          end else if (carrier_sync && state_q == ST_PRECHARGE) begin
            cnt_nxt = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == PC_LAST) begin
              state_nxt = ST_RUN;
              mods_nxt  = full_q ? shadow_q : '0;
              if (!take) full_nxt = 1'b0;
            end
          end else if (carrier_sync && full_q) begin
            mods_nxt = shadow_q;
            full_nxt = 1'b0;
          end
        end
        ST_FAULT: begin
          if (fault_clear && !fault_in) begin
            state_nxt = ST_DISABLED;
            full_nxt  = 1'b0;
          end
        end
        default: state_nxt = ST_DISABLED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: shadow_q data is not reset; full_q alone marks whether it holds anything.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q  <= ST_DISABLED;
      mods_q   <= '0;
      full_q   <= 1'b0;
      drv_q    <= 1'b0;
      cnt_q    <= '0;
      period_q <= period_in;
    end else begin
      state_q  <= state_nxt;
      mods_q   <= mods_nxt;
      full_q   <= full_nxt;
      drv_q    <= drv_nxt;
      cnt_q    <= cnt_nxt;
      period_q <= period_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    shadow_q <= shadow_nxt;
  end

  assign s.ready       = ready_w;
  assign pwm_period    = period_q;
  assign mod_a         = mods_q.a;
  assign mod_b         = mods_q.b;
  assign mod_c         = mods_q.c;
  assign drv_enable    = drv_q;
  assign state         = state_q;
  assign fault_latched = (state_q == ST_FAULT);

endmodule

// File: tb/tb_modulator_sequencer.sv
// Directed self-checking bench for modulator_sequencer: start-up, handshake,
// clamp, fault handling, period freeze and mid-run reset.
module tb_modulator_sequencer;
  localparam int W  = 16;
  localparam int PC = 8;

  logic                aclk = 1'b0;
  logic                resetn;
  logic                enable;
  logic                fault_in;
  logic                fault_clear;
  logic                carrier_sync;
  logic [W-1:0]        period_in;
  logic [W-1:0]        pwm_period;
  logic signed [W-1:0] mod_a, mod_b, mod_c;
  logic                drv_enable;
  logic [1:0]          state;
  logic                fault_latched;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  modulator_sequencer_if #(.W(W)) s_if ();

  modulator_sequencer #(.W(W), .PRECHARGE_CYCLES(PC)) dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .enable        (enable),
    .fault_in      (fault_in),
    .fault_clear   (fault_clear),
    .carrier_sync  (carrier_sync),
    .period_in     (period_in),
    .s             (s_if),
    .pwm_period    (pwm_period),
    .mod_a         (mod_a),
    .mod_b         (mod_b),
    .mod_c         (mod_c),
    .drv_enable    (drv_enable),
    .state         (state),
    .fault_latched (fault_latched)
  );

  // Sample 1 time unit after the active edge; inputs also change there.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic sync_pulse();
    carrier_sync = 1'b1;
    tick();
    carrier_sync = 1'b0;
    tick();
  endtask

  task automatic send(input int a, input int b, input int c);
    s_if.valid = 1'b1;
    s_if.mod_a = W'(a);
    s_if.mod_b = W'(b);
    s_if.mod_c = W'(c);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    period_in = 16'd1000;
    tick();
    tick();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (drv_enable !== 1'b0) begin n_fail++; $display("FAIL reset_drv: got %b expected 0", drv_enable); end
    n_checks++; if ({mod_a, mod_b, mod_c} !== '0) begin n_fail++; $display("FAIL reset_mods: got (%0d,%0d,%0d) expected (0,0,0)", mod_a, mod_b, mod_c); end
    n_checks++; if (pwm_period !== 16'd1000) begin n_fail++; $display("FAIL reset_period: got %0d expected 1000", pwm_period); end
    n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", s_if.ready); end
    n_checks++; if (fault_latched !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault_latched); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_startup();
    send(1, 2, 3);
    tick();
    send(300, -150, -150);
    tick();
    s_if.valid = 1'b0;
    n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL disabled_ready: got %b expected 1", s_if.ready); end
    enable = 1'b1;
    tick();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d expected 1", state); end
    n_checks++; if (drv_enable !== 1'b1) begin n_fail++; $display("FAIL start_drv: got %b expected 1", drv_enable); end
    n_checks++; if (mod_a !== -16'sd1000 || mod_b !== -16'sd1000 || mod_c !== -16'sd1000) begin n_fail++; $display("FAIL precharge_mods: got (%0d,%0d,%0d) expected (-1000,-1000,-1000)", mod_a, mod_b, mod_c); end
    repeat (PC - 1) sync_pulse();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL sync7_state: got %0d expected 1", state); end
    sync_pulse();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL sync8_state: got %0d expected 2", state); end
    n_checks++; if (mod_a !== 16'sd300 || mod_b !== -16'sd150 || mod_c !== -16'sd150) begin n_fail++; $display("FAIL run_commit: got (%0d,%0d,%0d) expected (300,-150,-150)", mod_a, mod_b, mod_c); end
    n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b expected 1", s_if.ready); end
  endtask

  task automatic test_handshake();
    send(100, 0, -100);
    tick();
    n_checks++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_drop: got %b expected 0", s_if.ready); end
    send(200, 0, -200);
    tick();
    tick();
    n_checks++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_hold: got %b expected 0", s_if.ready); end
    n_checks++; if (mod_a !== 16'sd300 || mod_b !== -16'sd150 || mod_c !== -16'sd150) begin n_fail++; $display("FAIL hs_no_early_commit: got (%0d,%0d,%0d) expected (300,-150,-150)", mod_a, mod_b, mod_c); end
    carrier_sync = 1'b1;
    tick();
    carrier_sync = 1'b0;
    n_checks++; if (mod_a !== 16'sd100 || mod_b !== 16'sd0 || mod_c !== -16'sd100) begin n_fail++; $display("FAIL hs_commit1: got (%0d,%0d,%0d) expected (100,0,-100)", mod_a, mod_b, mod_c); end
    n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_rise: got %b expected 1", s_if.ready); end
    tick();
    s_if.valid = 1'b0;
    n_checks++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL hs_second_accept: got %b expected 0", s_if.ready); end
    sync_pulse();
    n_checks++; if (mod_a !== 16'sd200 || mod_b !== 16'sd0 || mod_c !== -16'sd200) begin n_fail++; $display("FAIL hs_commit2: got (%0d,%0d,%0d) expected (200,0,-200)", mod_a, mod_b, mod_c); end
  endtask

  task automatic test_clamp();
    send(1500, -2000, 999);
    tick();
    s_if.valid = 1'b0;
    sync_pulse();
    n_checks++; if (mod_a !== 16'sd1000 || mod_b !== -16'sd1000 || mod_c !== 16'sd999) begin n_fail++; $display("FAIL clamp: got (%0d,%0d,%0d) expected (1000,-1000,999)", mod_a, mod_b, mod_c); end
  endtask

  task automatic test_period_freeze();
    period_in = 16'd500;
    tick();
    tick();
    n_checks++; if (pwm_period !== 16'd1000) begin n_fail++; $display("FAIL period_frozen: got %0d expected 1000", pwm_period); end
    enable = 1'b0;
    tick();
    n_checks++; if (state !== 2'd0 || drv_enable !== 1'b0) begin n_fail++; $display("FAIL stop_state: got state %0d drv %b expected 0 0", state, drv_enable); end
    n_checks++; if ({mod_a, mod_b, mod_c} !== '0) begin n_fail++; $display("FAIL stop_mods: got (%0d,%0d,%0d) expected (0,0,0)", mod_a, mod_b, mod_c); end
    tick();
    n_checks++; if (pwm_period !== 16'd500) begin n_fail++; $display("FAIL period_follow: got %0d expected 500", pwm_period); end
    period_in = 16'd1000;
    tick();
    n_checks++; if (pwm_period !== 16'd1000) begin n_fail++; $display("FAIL period_restore: got %0d expected 1000", pwm_period); end
  endtask

  task automatic test_fault();
    enable = 1'b1;
    tick();
    repeat (PC) sync_pulse();
    n_checks++; if (state !== 2'd2 || {mod_a, mod_b, mod_c} !== '0) begin n_fail++; $display("FAIL rerun_empty: got state %0d mods (%0d,%0d,%0d) expected 2 (0,0,0)", state, mod_a, mod_b, mod_c); end
    send(50, 50, 50);
    tick();
    s_if.valid = 1'b0;
    n_checks++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL fault_pre_full: got %b expected 0", s_if.ready); end
    fault_in = 1'b1;
    carrier_sync = 1'b1;
    tick();
    fault_in = 1'b0;
    carrier_sync = 1'b0;
    n_checks++; if (state !== 2'd3 || fault_latched !== 1'b1) begin n_fail++; $display("FAIL fault_entry: got state %0d latched %b expected 3 1", state, fault_latched); end
    n_checks++; if (drv_enable !== 1'b0 || {mod_a, mod_b, mod_c} !== '0) begin n_fail++; $display("FAIL fault_safe: got drv %b mods (%0d,%0d,%0d) expected 0 (0,0,0)", drv_enable, mod_a, mod_b, mod_c); end
    fault_in = 1'b1;
    fault_clear = 1'b1;
    tick();
    fault_in = 1'b0;
    fault_clear = 1'b0;
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL clear_ignored: got %0d expected 3", state); end
    tick();
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL fault_holds: got %0d expected 3", state); end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    n_checks++; if (state !== 2'd0 || fault_latched !== 1'b0) begin n_fail++; $display("FAIL fault_exit: got state %0d latched %b expected 0 0", state, fault_latched); end
    tick();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL restart: got %0d expected 1", state); end
    repeat (PC) sync_pulse();
    n_checks++; if (state !== 2'd2 || {mod_a, mod_b, mod_c} !== '0) begin n_fail++; $display("FAIL shadow_cleared: got state %0d mods (%0d,%0d,%0d) expected 2 (0,0,0)", state, mod_a, mod_b, mod_c); end
  endtask

  task automatic test_sync_vs_disable();
    send(10, 10, 10);
    tick();
    s_if.valid = 1'b0;
    enable = 1'b0;
    carrier_sync = 1'b1;
    tick();
    carrier_sync = 1'b0;
    n_checks++; if (state !== 2'd0 || drv_enable !== 1'b0 || {mod_a, mod_b, mod_c} !== '0) begin n_fail++; $display("FAIL disable_wins: got state %0d drv %b mods (%0d,%0d,%0d) expected 0 0 (0,0,0)", state, drv_enable, mod_a, mod_b, mod_c); end
    sync_pulse();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL sync_in_disabled: got %0d expected 0", state); end
  endtask

  task automatic test_reset_midway();
    enable = 1'b1;
    tick();
    repeat (5) sync_pulse();
    resetn = 1'b0;
    tick();
    n_checks++; if (state !== 2'd0 || drv_enable !== 1'b0 || {mod_a, mod_b, mod_c} !== '0) begin n_fail++; $display("FAIL midway_reset: got state %0d drv %b mods (%0d,%0d,%0d) expected 0 0 (0,0,0)", state, drv_enable, mod_a, mod_b, mod_c); end
    resetn = 1'b1;
    tick();
    n_checks++; if (state !== 2'd1 || mod_a !== -16'sd1000) begin n_fail++; $display("FAIL midway_restart: got state %0d mod_a %0d expected 1 -1000", state, mod_a); end
    repeat (PC - 1) sync_pulse();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL midway_count7: got %0d expected 1", state); end
    sync_pulse();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL midway_count8: got %0d expected 2", state); end
  endtask

  initial begin
    resetn       = 1'b0;
    enable       = 1'b0;
    fault_in     = 1'b0;
    fault_clear  = 1'b0;
    carrier_sync = 1'b0;
    period_in    = 16'd1000;
    s_if.valid   = 1'b0;
    s_if.mod_a   = '0;
    s_if.mod_b   = '0;
    s_if.mod_c   = '0;

    test_reset();
    test_startup();
    test_handshake();
    test_clamp();
    test_period_freeze();
    test_fault();
    test_sync_vs_disable();
    test_reset_midway();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
